muldiv_unit: RTL and testbench

Iterative 32-bit multiply/divide unit for the MIPS datapath, downstream of the register file. It consumes the two register read operands (RF_A, RF_B) and computes MULT/MULTU/DIV/DIVU over 32 iteration cycles. Results go into internal HI/LO registers, which feed mfhi/mflo back toward register-file write-back. A Start/Busy/Done handshake lets the control unit stall dependent instructions.

---
 rtl/muldiv_unit.sv | 137 +++++++++++++
 tb/tb_muldiv_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// Each operation takes 32 iteration cycles plus one sign-fix cycle.
module muldiv_unit (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Start,
  input  logic [1:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        HiWrEn,
  input  logic        LoWrEn,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Hi,
  output logic [31:0] Lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state, state_next;
  logic [1:0]  op_q;
  logic [31:0] mag_a, mag_b, raw_a;
  logic        sign_a, sign_b;
  logic [63:0] work;
  logic [4:0]  cnt;

  logic        start_signed;
  logic        is_div;
  logic [32:0] mul_sum;
  logic [32:0] div_trial;
  logic [32:0] div_diff;
  logic [63:0] iter_work;
  logic [63:0] prod_fix;
  logic [31:0] quot_fix, rem_fix;
  logic [31:0] fix_hi, fix_lo;

  assign start_signed = ~Op[0];
  assign is_div       = op_q[1];

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Start) state_next = CALC;
      CALC:    if (cnt == 5'd31) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state <= IDLE;
      Busy  <= 1'b0;
    end else begin
      state <= state_next;
      Busy  <= (state_next != IDLE);
    end
  end

  // Multiply shifts the accumulator right each step; divide shifts the
  // {remainder, quotient} pair left, pulling in dividend bits MSB first.
  always_comb begin
    mul_sum   = {1'b0, work[63:32]} + (mag_b[cnt] ? {1'b0, mag_a} : 33'd0);
    div_trial = {work[63:32], mag_a[5'd31 - cnt]};
    div_diff  = div_trial - {1'b0, mag_b};
    iter_work = {mul_sum, work[31:1]};
    if (is_div) begin
      if (div_trial >= {1'b0, mag_b})
        iter_work = {div_diff[31:0], work[30:0], 1'b1};
      else
        iter_work = {div_trial[31:0], work[30:0], 1'b0};
    end
  end

  always_comb begin
    prod_fix = (!op_q[0] && (sign_a ^ sign_b)) ? (64'd0 - work) : work;
    quot_fix = (!op_q[0] && (sign_a ^ sign_b)) ? (32'd0 - work[31:0]) : work[31:0];
    rem_fix  = (!op_q[0] && sign_a) ? (32'd0 - work[63:32]) : work[63:32];
    fix_hi   = prod_fix[63:32];
    fix_lo   = prod_fix[31:0];
    if (is_div) begin
      // Divide by zero keeps full latency and reports the raw dividend.
      if (mag_b == 32'd0) begin
        fix_hi = raw_a;
        fix_lo = 32'hFFFF_FFFF;
      end else begin
        fix_hi = rem_fix;
        fix_lo = quot_fix;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      Hi     <= 32'd0;
      Lo     <= 32'd0;
      Done   <= 1'b0;
      cnt    <= 5'd0;
      work   <= 64'd0;
      op_q   <= 2'd0;
      mag_a  <= 32'd0;
      mag_b  <= 32'd0;
      raw_a  <= 32'd0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
    end else begin
      Done <= (state == FIX);
      case (state)
        IDLE: begin
          if (Start) begin
            op_q   <= Op;
            raw_a  <= A;
            sign_a <= start_signed & A[31];
            sign_b <= start_signed & B[31];
            mag_a  <= (start_signed && A[31]) ? (32'd0 - A) : A;
            mag_b  <= (start_signed && B[31]) ? (32'd0 - B) : B;
            work   <= 64'd0;
            cnt    <= 5'd0;
          end else begin
            if (HiWrEn) Hi <= A;
            if (LoWrEn) Lo <= A;
          end
        end
        CALC: begin
          work <= iter_work;
          cnt  <= cnt + 5'd1;
        end
        FIX: begin
          Hi <= fix_hi;
          Lo <= fix_lo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit using a result scoreboard.
// Expected HI/LO values are computed by hand and queued at Start time.
module tb_muldiv_unit;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Start = 1'b0;
  logic [1:0]  Op = 2'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        HiWrEn = 1'b0;
  logic        LoWrEn = 1'b0;
  logic        Busy, Done;
  logic [31:0] Hi, Lo;

  localparam logic [1:0] MULT  = 2'b00;
  localparam logic [1:0] MULTU = 2'b01;
  localparam logic [1:0] DIV   = 2'b10;
  localparam logic [1:0] DIVU  = 2'b11;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sbQueue[$];
  int   testCount = 0;
  int   failCount = 0;
  int   cycleCount = 0;
  int   startCycle = 0;
  int   busyCount = 0;
  logic doneSeen;

  muldiv_unit dut (
    .Clk    (Clk),
    .Rst_n  (Rst_n),
    .Start  (Start),
    .Op     (Op),
    .A      (A),
    .B      (B),
    .HiWrEn (HiWrEn),
    .LoWrEn (LoWrEn),
    .Busy   (Busy),
    .Done   (Done),
    .Hi     (Hi),
    .Lo     (Lo)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cycleCount++;
  always @(negedge Clk) if (Busy === 1'b1) busyCount++;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drives one Start request, queues its expected result, then scrambles
  // the operand inputs to show they are only sampled at acceptance.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic pushExp, input logic [31:0] expHi,
                               input logic [31:0] expLo, input string tag);
    exp_t e;
    @(negedge Clk);
    Start = 1'b1;
    Op = op;
    A = a;
    B = b;
    if (pushExp) begin
      e.tag = tag;
      e.hi = expHi;
      e.lo = expLo;
      sbQueue.push_back(e);
    end
    @(posedge Clk);
    busyCount = 0;
    #1;
    startCycle = cycleCount;
    Start = 1'b0;
    Op = ~op;
    A = ~a;
    B = ~b;
    check({tag, " busy@accept"}, {31'd0, Busy}, 32'd1);
    check({tag, " done@accept"}, {31'd0, Done}, 32'd0);
  endtask

  task automatic checkOutput();
    exp_t e;
    while (Done !== 1'b1 && (cycleCount - startCycle) < 100) begin
      @(posedge Clk);
      #1;
    end
    if (sbQueue.size() == 0) begin
      testCount++;
      failCount++;
      $error("[TB] FAIL scoreboard observed=empty expected=entry");
    end else begin
      e = sbQueue.pop_front();
      check({e.tag, " done"}, {31'd0, Done}, 32'd1);
      check({e.tag, " latency"}, cycleCount - startCycle, 32'd33);
      check({e.tag, " busycycles"}, busyCount, 32'd33);
      check({e.tag, " busy@done"}, {31'd0, Busy}, 32'd0);
      check({e.tag, " hi"}, Hi, e.hi);
      check({e.tag, " lo"}, Lo, e.lo);
    end
  endtask

  initial begin
    repeat (2) @(posedge Clk);
    #1;
    check("reset busy", {31'd0, Busy}, 32'd0);
    check("reset done", {31'd0, Done}, 32'd0);
    check("reset hi", Hi, 32'd0);
    check("reset lo", Lo, 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;

    applyStimulus(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
    checkOutput();
    // Back-to-back: this Start is raised in the Done cycle.
    applyStimulus(MULT, 32'hFFFF_FFFD, 32'd5, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_neg");
    checkOutput();
    applyStimulus(DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7_2");
    checkOutput();
    applyStimulus(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, "div_ovf");
    checkOutput();
    applyStimulus(DIV, 32'd100, 32'hFFFF_FFF9, 1'b1, 32'd2, 32'hFFFF_FFF2, "div_100_neg7");
    checkOutput();
    applyStimulus(DIV, 32'hFFFF_FFF9, 32'd0, 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_zero");
    checkOutput();
    applyStimulus(DIVU, 32'd7, 32'd0, 1'b1, 32'd7, 32'hFFFF_FFFF, "divu_zero");
    checkOutput();
    @(posedge Clk);
    #1;
    check("divu_zero done_drop", {31'd0, Done}, 32'd0);
    check("divu_zero hi_hold", Hi, 32'd7);

    @(negedge Clk);
    HiWrEn = 1'b1;
    A = 32'h1234_5678;
    @(posedge Clk);
    #1;
    HiWrEn = 1'b0;
    check("mthi hi", Hi, 32'h1234_5678);
    check("mthi lo", Lo, 32'hFFFF_FFFF);

    // mtlo coinciding with Start must be dropped.
    LoWrEn = 1'b1;
    applyStimulus(MULTU, 32'd6, 32'd7, 1'b1, 32'd0, 32'd42, "multu_ignore");
    LoWrEn = 1'b0;
    check("mtlo_with_start lo", Lo, 32'hFFFF_FFFF);
    repeat (4) @(posedge Clk);
    @(negedge Clk);
    Start = 1'b1;
    HiWrEn = 1'b1;
    Op = DIVU;
    A = 32'd9;
    B = 32'd3;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    HiWrEn = 1'b0;
    check("busy_start busy", {31'd0, Busy}, 32'd1);
    check("busy_mthi hi", Hi, 32'h1234_5678);
    checkOutput();

    applyStimulus(MULTU, 32'd6, 32'd7, 1'b0, 32'd0, 32'd0, "multu_abort");
    repeat (8) @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b0;
    @(posedge Clk);
    #1;
    check("abort hi", Hi, 32'd0);
    check("abort lo", Lo, 32'd0);
    check("abort busy", {31'd0, Busy}, 32'd0);
    check("abort done", {31'd0, Done}, 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    doneSeen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge Clk);
      #1;
      if (Done === 1'b1) doneSeen = 1'b1;
    end
    check("abort no_done", {31'd0, doneSeen}, 32'd0);
    check("abort lo_hold", Lo, 32'd0);

    applyStimulus(MULT, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 32'hC000_0000, 32'h8000_0000, "mult_extreme");
    checkOutput();

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
